// File: rtl/cond_issue_queue.sv
// Conditional issue queue: evaluates ARM-style condition codes against
// the flags, enqueues passing words into a small FIFO and counts squashed words.
module cond_issue_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [DATA_W-1:0]          inData,
  input  logic [31:0]                cpsr,
  input  logic                       flush,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [DATA_W-1:0]          outData,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           issueCnt,
  output logic [CNT_W-1:0]           squashCnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic              live;
  logic              condPass;
  logic              accept;
  logic              push;
  logic              drop;
  logic              pop;
  logic [3:0]        cond;
  logic              n, z, c, v;

  assign cond = inData[DATA_W-1 -: 4];
  assign n    = cpsr[31];
  assign z    = cpsr[30];
  assign c    = cpsr[29];
  assign v    = cpsr[28];

  // condition code evaluation against the current flags
  always_comb begin
    condPass = 1'b0;
    unique case (cond)
      4'h0: condPass = z;
      4'h1: condPass = !z;
      4'h2: condPass = c;
      4'h3: condPass = !c;
      4'h4: condPass = n;
      4'h5: condPass = !n;
      4'h6: condPass = v;
      4'h7: condPass = !v;
      4'h8: condPass = c && !z;
      4'h9: condPass = !c || z;
      4'hA: condPass = (n == v);
      4'hB: condPass = (n != v);
      4'hC: condPass = !z && (n == v);
      4'hD: condPass = z || (n != v);
      4'hE: condPass = 1'b1;
      4'hF: condPass = 1'b0;
    endcase
  end

  // handshake qualification; ready held low until the first edge after reset
  always_comb begin
    outValid = (level != '0);
    outData  = outValid ? mem[rdPtr] : '0;
    inReady  = live && (level < FULL) && !flush;
    accept   = inValid && inReady;
    push     = accept && condPass;
    drop     = accept && !condPass;
    pop      = outValid && outReady && !flush;
  end

  // storage needs no reset; contents are masked by level
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= inData;
  end

  // pointers, occupancy and ready-enable
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      live  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        level <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PW'(1);
        if (pop)  rdPtr <= rdPtr + PW'(1);
        if (push && !pop)
          level <= level + LW'(1);
        else if (pop && !push)
          level <= level - LW'(1);
      end
    end
  end

  // saturating statistics, untouched by flush
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      issueCnt  <= '0;
      squashCnt <= '0;
    end else begin
      if (push && issueCnt != '1)
        issueCnt <= issueCnt + CNT_W'(1);
      if (drop && squashCnt != '1)
        squashCnt <= squashCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_issue_queue.sv
// Testbench for cond_issue_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_cond_issue_queue;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic [31:0] cpsr;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [2:0]  level;
  logic [15:0] issueCnt;
  logic [15:0] squashCnt;

  cond_issue_queue dut (
    .clk(clk), .rstN(rstN),
    .inValid(inValid), .inReady(inReady), .inData(inData),
    .cpsr(cpsr), .flush(flush),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .level(level), .issueCnt(issueCnt), .squashCnt(squashCnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] q[$];
  int mIssue = 0;
  int mSquash = 0;
  bit mLive = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ARM structure: code pairs share a predicate, odd code inverts it
  function automatic bit condRef(logic [3:0] code, logic [3:0] f);
    bit nn = f[3];
    bit zz = f[2];
    bit cc = f[1];
    bit vv = f[0];
    bit base = 0;
    if (code == 4'hE) return 1;
    if (code == 4'hF) return 0;
    case (int'(code) / 2)
      0: base = zz;
      1: base = cc;
      2: base = nn;
      3: base = vv;
      4: base = cc && !zz;
      5: base = (nn == vv);
      6: base = !zz && (nn == vv);
      default: base = 0;
    endcase
    return code[0] ? !base : base;
  endfunction

  task automatic checkOuts(string tag);
    chk({tag, ".level"}, 64'(level), 64'(q.size()));
    chk({tag, ".outValid"}, 64'(outValid), 64'(q.size() != 0));
    chk({tag, ".outData"}, 64'(outData), 64'(q.size() != 0 ? q[0] : 32'h0));
    chk({tag, ".issueCnt"}, 64'(issueCnt), 64'(mIssue));
    chk({tag, ".squashCnt"}, 64'(squashCnt), 64'(mSquash));
  endtask

  // one clock: check ready, predict the edge, then check outputs after it
  task automatic cycle(string tag);
    bit rdy;
    bit acc;
    bit pass;
    bit pp;
    logic [31:0] w;
    #1;
    rdy = mLive && q.size() < 4 && !flush;
    chk({tag, ".inReady"}, 64'(inReady), 64'(rdy));
    acc = inValid && rdy;
    pass = condRef(inData[31:28], cpsr[31:28]);
    pp = !flush && q.size() != 0 && outReady;
    w = inData;
    @(posedge clk);
    mLive = 1;
    if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc && pass) begin
        q.push_back(w);
        if (mIssue < 65535) mIssue++;
      end else if (acc) begin
        if (mSquash < 65535) mSquash++;
      end
    end
    #1;
    checkOuts(tag);
  endtask

  task automatic checkReset(string tag);
    q.delete();
    mIssue = 0;
    mSquash = 0;
    mLive = 0;
    chk({tag, ".inReady"}, 64'(inReady), 64'h0);
    checkOuts(tag);
  endtask

  initial begin
    rstN = 0;
    inValid = 0;
    inData = 0;
    cpsr = 0;
    flush = 0;
    outReady = 0;
    #3;
    checkReset("rst0");
    #9;
    rstN = 1;
    cycle("idle");

    // EQ passes with Z set
    cpsr = 32'h4000_0000;
    inValid = 1;
    inData = 32'h0AAA_AAAA;
    cycle("eq");
    inValid = 0;
    cycle("eqHold");
    chk("eq.data", 64'(outData), 64'h0AAA_AAAA);

    // drain, then NE and never are squashed
    outReady = 1;
    cycle("drain");
    outReady = 0;
    inValid = 1;
    inData = 32'h1BBB_BBBB;
    cycle("ne");
    inData = 32'hF000_0000;
    cycle("nv");
    inValid = 0;
    cycle("nvHold");

    // full code x flag sweep
    outReady = 1;
    inValid = 1;
    for (int code = 0; code < 16; code++) begin
      for (int f = 0; f < 16; f++) begin
        cpsr = {4'(f), 28'h0};
        inData = {4'(code), 28'(code * 16 + f)};
        cycle("sweep");
      end
    end
    inValid = 0;
    cycle("sweepEnd");

    // fill to full, fifth word refused, then stream across wrap
    outReady = 0;
    inValid = 1;
    cpsr = 0;
    for (int i = 0; i < 5; i++) begin
      inData = 32'hE000_0100 + 32'(i);
      cycle("fill");
    end
    outReady = 1;
    for (int i = 0; i < 10; i++) begin
      inData = 32'hE000_0200 + 32'(i);
      cycle("wrap");
    end
    inValid = 0;
    for (int i = 0; i < 5; i++) cycle("empty");

    // flush with three queued and a word offered
    outReady = 0;
    inValid = 1;
    for (int i = 0; i < 3; i++) begin
      inData = 32'hE000_0300 + 32'(i);
      cycle("preFlush");
    end
    flush = 1;
    inData = 32'hE000_03FF;
    cycle("flush");
    flush = 0;
    inValid = 0;
    cycle("postFlush");

    // asynchronous reset with two queued
    inValid = 1;
    for (int i = 0; i < 2; i++) begin
      inData = 32'hE000_0400 + 32'(i);
      cycle("preRst");
    end
    inValid = 0;
    #2;
    rstN = 0;
    #1;
    checkReset("rstMid");
    #3;
    rstN = 1;
    inValid = 1;
    inData = 32'hE000_0500;
    cycle("rstFirst");
    cycle("rstResume");
    inValid = 0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      inValid = 1'($urandom);
      inData = $urandom;
      cpsr = $urandom;
      outReady = 1'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end
    flush = 0;
    inValid = 0;
    outReady = 1;
    for (int i = 0; i < 5; i++) cycle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
